// File: rtl/arbitro_memoria_pkg.sv
// Shared constants for the two-port memory arbiter.
//   arb_state_e    : FSM state encoding (IDLE = 0, ACCESS = 1, DONE = 2)
//   DimDefault     : default data memory depth in 32-bit words
//   addr_in_range  : true when a word address falls inside 0..dim-1
package arbitro_memoria_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StDone   = 2'd2
  } arb_state_e;

  localparam int unsigned DimDefault = 1024;

  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned dim);
    return addr < dim;
  endfunction

endpackage

// File: rtl/arbitro_memoria.sv
// Two-requester round-robin arbiter in front of a single-port data memory.
// One access every three cycles: IDLE samples requests, ACCESS drives the
// memory, DONE presents the registered response with a one-cycle ACK.
// Ports:
//   CLK, RST                    clock, synchronous active-high reset
//   REQn, WEn, ADDRn, WDATAn    request, write enable, word address, write data
//   ACKn, RDATAn, ERRn          completion pulse, read data, out-of-range flag
//   MEM_WE, MEM_ADDRESS,
//   MEM_DATA, MEM_Q             external memory interface (MEM_Q combinational)
module arbitro_memoria
  import arbitro_memoria_pkg::*;
#(
  parameter int unsigned DIM = DimDefault
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ0,
  input  logic        REQ1,
  input  logic        WE0,
  input  logic        WE1,
  input  logic [31:0] ADDR0,
  input  logic [31:0] ADDR1,
  input  logic [31:0] WDATA0,
  input  logic [31:0] WDATA1,
  output logic        ACK0,
  output logic        ACK1,
  output logic [31:0] RDATA0,
  output logic [31:0] RDATA1,
  output logic        ERR0,
  output logic        ERR1,
  output logic        MEM_WE,
  output logic [31:0] MEM_ADDRESS,
  output logic [31:0] MEM_DATA,
  input  logic [31:0] MEM_Q
);

  arb_state_e  r_state;
  logic        r_last;   // port granted most recently
  logic        r_id;     // port being served
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_ack0;
  logic        r_ack1;
  logic [31:0] r_rdata0;
  logic [31:0] r_rdata1;
  logic        r_err0;
  logic        r_err1;

  logic        w_any_req;
  logic        w_winner;
  logic        w_in_range;
  logic [31:0] w_rsp_data;

  assign w_any_req = REQ0 | REQ1;
  // On a tie the port that did not win last time is served.
  assign w_winner  = (REQ0 & REQ1) ? ~r_last : REQ1;

  assign w_in_range = addr_in_range(r_addr, DIM);
  assign w_rsp_data = (!r_we && w_in_range) ? MEM_Q : 32'h0;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= StIdle;
      r_last   <= 1'b1;
      r_id     <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= 32'h0;
      r_wdata  <= 32'h0;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_rdata0 <= 32'h0;
      r_rdata1 <= 32'h0;
      r_err0   <= 1'b0;
      r_err1   <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_any_req) begin
            r_state <= StAccess;
            r_id    <= w_winner;
            r_last  <= w_winner;
            r_we    <= w_winner ? WE1 : WE0;
            r_addr  <= w_winner ? ADDR1 : ADDR0;
            r_wdata <= w_winner ? WDATA1 : WDATA0;
          end
        end
        StAccess: begin
          r_state <= StDone;
          r_ack0  <= ~r_id;
          r_ack1  <= r_id;
          if (r_id) begin
            r_rdata1 <= w_rsp_data;
            r_err1   <= ~w_in_range;
          end else begin
            r_rdata0 <= w_rsp_data;
            r_err0   <= ~w_in_range;
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
        end
        default: begin
          r_state <= StIdle;
          r_ack0  <= 1'b0;
          r_ack1  <= 1'b0;
        end
      endcase
    end
  end

  // RST gates the strobe so a reset landing mid-access cannot corrupt memory.
  assign MEM_WE      = (r_state == StAccess) & r_we & w_in_range & ~RST;
  assign MEM_ADDRESS = r_addr;
  assign MEM_DATA    = r_wdata;

  assign ACK0   = r_ack0;
  assign ACK1   = r_ack1;
  assign RDATA0 = r_rdata0;
  assign RDATA1 = r_rdata1;
  assign ERR0   = r_err0;
  assign ERR1   = r_err1;

endmodule

// File: doc/arbitro_memoria.md
ARBITRO_MEMORIA -- requirements
Module: arbitro_memoria

Interface
REQ-001 Parameter: DIM, 1024, number of 32-bit words in the attached data memory; valid word addresses are 0..DIM-1.
REQ-002 Port: CLK  input  1  single clock; all state changes on posedge CLK.
REQ-003 Port: RST  input  1  reset, synchronous and active-high.
REQ-004 Port: REQ0 / REQ1  input  1  access request from requester 0 / 1.
REQ-005 Port: WE0 / WE1  input  1  1 = write, 0 = read; sampled with REQn.
REQ-006 Port: ADDR0 / ADDR1  input  32  word address; sampled with REQn.
REQ-007 Port: WDATA0 / WDATA1  input  32  write data; sampled with REQn.
REQ-008 Port: ACK0 / ACK1  output  1  one-cycle completion pulse to requester 0 / 1.
REQ-009 Port: RDATA0 / RDATA1  output  32  read data; valid while ACKn = 1, 0 for writes and errors.
REQ-010 Port: ERR0 / ERR1  output  1  out-of-range flag; valid while ACKn = 1.
REQ-011 Port: MEM_WE  output  1  write enable to the data memory.
REQ-012 Port: MEM_ADDRESS  output  32  address to the data memory.
REQ-013 Port: MEM_DATA  output  32  write data to the data memory.
REQ-014 Port: MEM_Q  input  32  combinational read data from the data memory.

Function
REQ-015 FSM states: IDLE, ACCESS, DONE; IDLE->ACCESS when REQ0 or REQ1 is sampled high; ACCESS->DONE unconditionally; DONE->IDLE unconditionally.
REQ-016 On the IDLE->ACCESS edge, the block SHALL latch the winner's id, WE, ADDR and WDATA; the requester's fields are don't-care afterwards.
REQ-017 Winner: the sole requester if only one is high; if both, the port other than pointer LAST; LAST := winner on every grant.
REQ-018 In ACCESS: MEM_ADDRESS = latched ADDR; MEM_DATA = latched WDATA; MEM_WE = latched WE AND in-range AND NOT RST.
REQ-019 In-range means latched ADDR < DIM; an out-of-range access SHALL not write memory and SHALL return RDATA = 0 with ERR = 1.
REQ-020 At the ACCESS->DONE edge, the block SHALL register MEM_Q for in-range reads, or 0 otherwise, into the winner's RDATA.
REQ-021 In DONE: the winner's ACK = 1 for exactly one cycle and the loser's ACK = 0; ACK0 and ACK1 are never high together.
REQ-022 Latency: REQ sampled at edge k -> memory access in cycle k+1 -> ACK high in cycle k+2; throughput is one access per 3 cycles.
REQ-023 REQ still high at the end of the DONE cycle SHALL be sampled in the following IDLE cycle as a new request.
REQ-024 A requester that wants a single access SHALL drop REQ on the edge where it samples ACK = 1.
REQ-025 A request arriving while ACCESS or DONE is active SHALL wait, with no loss and no ACK, until the next IDLE evaluation.
REQ-026 RDATAn and ERRn SHALL hold their last values outside DONE; they are defined only while ACKn = 1.
REQ-027 Outside ACCESS, MEM_WE = 0, and MEM_ADDRESS / MEM_DATA hold the latched values.

Reset
REQ-028 When RST is high at a posedge, the block SHALL set state = IDLE, LAST = 1 (port 0 wins the first tie), all latches = 0, ACKn = 0, RDATAn = 0, ERRn = 0, MEM_WE = 0, MEM_ADDRESS = 0 and MEM_DATA = 0.
REQ-029 RST asserted in ACCESS SHALL suppress the memory write via the MEM_WE gating and SHALL issue no ACK; an in-flight request is discarded.

Structure
REQ-030 State encodings (IDLE = 0, ACCESS = 1, DONE = 2) and the DIM default SHALL live in the shared processor constants package/include.
REQ-031 No sub-module is required: the round-robin pick and the FSM are inline, and the memory is external.

Verification
REQ-032 Single write then read: REQ0, WE0 = 1, ADDR0 = 5, WDATA0 = 0xDEADBEEF -> ACK0 two cycles later, mem[5] = 0xDEADBEEF; then a read of 5 -> RDATA0 = 0xDEADBEEF with ACK0.
REQ-033 Simultaneous requests after reset: REQ0 and REQ1 held high, reads of 1 and 2 -> ACK0 first, then ACK1 three cycles later, then ACK0 again (alternation).
REQ-034 Out-of-range write: REQ1, WE1 = 1, ADDR1 = 1024, WDATA1 = 0x1 -> ACK1 with ERR1 = 1 and RDATA1 = 0; mem[0] and mem[1023] remain unchanged.
REQ-035 Reset mid-access: REQ0 writes 0xAAAA5555 to 7, with RST high during ACCESS -> mem[7] unchanged, no ACK0, state IDLE, all outputs 0.
REQ-036 Late arrival: REQ1 rises during port 0's ACCESS -> ACK1 exactly 3 cycles after ACK0, never simultaneous with it.
